scr1_dmem_ocram_bridge: RTL

- Upstream stage for the 64-bit single-port on-chip RAM (8192 x 64, 64 KiB, 13-bit word address, 8-bit byteenable, one-cycle read latency).
- Converts the SCR1 32-bit data-memory request/response interface into Avalon-style RAM accesses.
- Handles window decode, alignment checks, byte-enable generation, data lane steering and read-latency tracking.
- Supports one outstanding transaction.

---
 rtl/scr1_ocram_pkg.sv | 43 ++++
 rtl/scr1_ocram_be_gen.sv | 39 +++
 rtl/scr1_dmem_ocram_bridge.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/scr1_ocram_pkg.sv
// Shared definitions for the SCR1 data-memory to on-chip RAM bridge.
// Holds the FSM state type, the SCR1 width and response codes and the
// RAM geometry defaults used by the bridge and its byte-enable generator.
// Optional read line buffer: define SCR1_OCRAM_RDBUF_EN to add the HIT state.

package scr1_ocram_pkg;

  // Default RAM word-address width (8192 x 64-bit words).
  localparam int OCRAM_AW_DFLT = 13;

  // Number of byte-offset bits inside one 64-bit RAM word.
  localparam int OCRAM_LANE_BITS = 3;

  // Size of the RAM window in bytes for the default geometry.
  localparam logic [31:0] OCRAM_WIN_BYTES = 32'(1) << (OCRAM_AW_DFLT + OCRAM_LANE_BITS);

  // SCR1 access width codes.
  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2,
    WIDTH_RSVD = 2'd3
  } dmem_width_e;

  // SCR1 response codes.
  typedef enum logic [1:0] {
    RESP_IDLE   = 2'd0,
    RESP_RDY_OK = 2'd1,
    RESP_RDY_ER = 2'd2
  } dmem_resp_e;

  // Bridge transaction states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_RDATA = 3'd2,
    ST_ERR   = 3'd3
`ifdef SCR1_OCRAM_RDBUF_EN
    , ST_HIT = 3'd4
`endif
  } ocram_state_e;

endpackage

// File: rtl/scr1_ocram_be_gen.sv
// Byte-enable generator for the 64-bit RAM port.
// Turns an SCR1 access width and the byte offset inside the 64-bit word
// into the eight RAM byte lanes, and flags accesses that straddle their
// natural alignment. The reserved width yields no lanes and no misalign
// flag; the bridge rejects it separately.

module scr1_ocram_be_gen
  import scr1_ocram_pkg::*;
(
  input  logic [1:0] width_i,
  input  logic [2:0] offs_i,
  output logic [7:0] be_o,
  output logic       misalign_o
);

  // Shift the base lane mask for the access width up to the byte offset.
  always_comb begin
    be_o       = 8'h00;
    misalign_o = 1'b0;
    case (width_i)
      WIDTH_BYTE: begin
        be_o = 8'h01 << offs_i;
      end
      WIDTH_HALF: begin
        be_o       = 8'h03 << offs_i;
        misalign_o = offs_i[0];
      end
      WIDTH_WORD: begin
        be_o       = 8'h0F << offs_i;
        misalign_o = |offs_i[1:0];
      end
      default: begin
        be_o       = 8'h00;
        misalign_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/scr1_dmem_ocram_bridge.sv
// SCR1 32-bit data-memory port to 64-bit single-port on-chip RAM bridge.
// One outstanding transaction. Writes respond one cycle after acceptance,
// reads two cycles after (RAM has one cycle read latency), errors one cycle.
// Optional macro SCR1_OCRAM_RDBUF_EN adds a one-line 64-bit read buffer
// that lets a repeated read of the same RAM word respond in one cycle.

module scr1_dmem_ocram_bridge
  import scr1_ocram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RAM_AW    = OCRAM_AW_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_req,
  output logic              dmem_req_ack,
  input  logic              dmem_cmd,
  input  logic [1:0]        dmem_width,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic [1:0]        dmem_resp,
  output logic [RAM_AW-1:0] avm_address,
  output logic [7:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [63:0]       avm_writedata,
  input  logic [63:0]       avm_readdata,
  output logic              avm_clken
);

  localparam int OffsW = RAM_AW + OCRAM_LANE_BITS;

  ocram_state_e      state_q, state_d;
  logic              cmd_q;
  logic              rdHi_q;
  logic              avmCs_q;
  logic              avmWrite_q;
  logic [RAM_AW-1:0] avmAddr_q;
  logic [7:0]        avmBe_q;
  logic [63:0]       avmWdata_q;

  logic              accept;
  logic              outOfWin;
  logic              reqErr;
  logic              reqMisalign;
  logic [7:0]        reqBe;
  logic [RAM_AW-1:0] reqLine;
  logic              reqHit;

  scr1_ocram_be_gen u_be_gen (
    .width_i    (dmem_width),
    .offs_i     (dmem_addr[2:0]),
    .be_o       (reqBe),
    .misalign_o (reqMisalign)
  );

  // Decode the incoming request: window check, alignment and target RAM word.
  always_comb begin
    accept   = dmem_req & dmem_req_ack;
    outOfWin = dmem_addr[31:OffsW] != BASE_ADDR[31:OffsW];
    reqErr   = outOfWin | (dmem_width == WIDTH_RSVD) | reqMisalign;
    reqLine  = dmem_addr[OffsW-1:OCRAM_LANE_BITS];
  end

`ifdef SCR1_OCRAM_RDBUF_EN
  logic [63:0]       bufData_q;
  logic [RAM_AW-1:0] bufTag_q;
  logic              bufValid_q;

  // A read hits when the buffered RAM word is the one being requested.
  always_comb begin
    reqHit = bufValid_q & ~dmem_cmd & (bufTag_q == reqLine);
  end

  // Fill the buffer from every RAM read; drop it when that word is rewritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      bufData_q  <= '0;
      bufTag_q   <= '0;
      bufValid_q <= 1'b0;
    end else if (state_q == ST_RDATA) begin
      bufData_q  <= avm_readdata;
      bufTag_q   <= avmAddr_q;
      bufValid_q <= 1'b1;
    end else if (accept && dmem_cmd && !reqErr && (reqLine == bufTag_q)) begin
      bufValid_q <= 1'b0;
    end
  end
`else
  // Without the buffer every read goes to the RAM.
  always_comb begin
    reqHit = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transaction in flight, back to IDLE after each response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reqErr) begin
            state_d = ST_ERR;
          end else begin
`ifdef SCR1_OCRAM_RDBUF_EN
            state_d = reqHit ? ST_HIT : ST_ISSUE;
`else
            state_d = ST_ISSUE;
`endif
          end
        end
      end
      ST_ISSUE: begin
        state_d = cmd_q ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
`ifdef SCR1_OCRAM_RDBUF_EN
      ST_HIT: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Keep the command and the 32-bit half select of the accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= 1'b0;
      rdHi_q <= 1'b0;
    end else if (accept) begin
      cmd_q  <= dmem_cmd;
      rdHi_q <= dmem_addr[2];
    end
  end

  // Register the RAM strobe so it is high for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      avmCs_q    <= 1'b0;
      avmWrite_q <= 1'b0;
      avmAddr_q  <= '0;
      avmBe_q    <= '0;
      avmWdata_q <= '0;
    end else if (state_d == ST_ISSUE) begin
      avmCs_q    <= 1'b1;
      avmWrite_q <= dmem_cmd;
      avmAddr_q  <= reqLine;
      avmBe_q    <= reqBe;
      avmWdata_q <= {dmem_wdata, dmem_wdata};
    end else begin
      avmCs_q    <= 1'b0;
      avmWrite_q <= 1'b0;
    end
  end

  // Core-side outputs decoded from the state; nothing is reported while in reset.
  always_comb begin
    dmem_req_ack = (state_q == ST_IDLE) & ~reset;
    dmem_resp    = RESP_IDLE;
    dmem_rdata   = '0;
    if (!reset) begin
      case (state_q)
        ST_ISSUE: begin
          if (cmd_q) begin
            dmem_resp = RESP_RDY_OK;
          end
        end
        ST_RDATA: begin
          dmem_resp  = RESP_RDY_OK;
          dmem_rdata = rdHi_q ? avm_readdata[63:32] : avm_readdata[31:0];
        end
        ST_ERR: begin
          dmem_resp = RESP_RDY_ER;
        end
`ifdef SCR1_OCRAM_RDBUF_EN
        ST_HIT: begin
          dmem_resp  = RESP_RDY_OK;
          dmem_rdata = rdHi_q ? bufData_q[63:32] : bufData_q[31:0];
        end
`endif
        default: begin
          dmem_resp  = RESP_IDLE;
          dmem_rdata = '0;
        end
      endcase
    end
  end

  // Drive the RAM port from the registered strobe.
  always_comb begin
    avm_chipselect = avmCs_q;
    avm_write      = avmWrite_q;
    avm_address    = avmAddr_q;
    avm_byteenable = avmBe_q;
    avm_writedata  = avmWdata_q;
    avm_clken      = 1'b1;
  end

endmodule
